fifo_flow_buf: RTL and testbench



---
 rtl/fifo_flow_buf_pkg.sv | 21 ++
 rtl/fifo_mem_dp.sv | 47 ++++
 rtl/fifo_flow_buf.sv | 99 +++++++++
 tb/tb_fifo_flow_buf.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_flow_buf_pkg.sv
// Shared defaults, pointer-width helper and op encoding for fifo_flow_buf.
// Used by the FIFO core, its memory and ingress/tester instances.
package fifo_flow_buf_pkg;

    localparam int DEF_DATA_SIZE       = 10;
    localparam int DEF_MAIN_SIZE       = 8;
    localparam int DEF_ALMOST_FULL_TH  = 6;
    localparam int DEF_ALMOST_EMPTY_TH = 2;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic int fifo_clog2(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// MAIN_SIZE x DATA_SIZE storage, one synchronous write port.
// Read port registered by default, combinational under FIFO_FWFT_EN.
module fifo_mem_dp
    import fifo_flow_buf_pkg::*;
#(
    parameter int DW    = DEF_DATA_SIZE,
    parameter int DEPTH = DEF_MAIN_SIZE,
    parameter int AW    = fifo_clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    logic w_unused;
    assign w_unused = &{1'b0, i_re, i_rst};
    assign o_rdata  = r_mem[i_raddr];
`else
    logic [DW-1:0] r_rdata;

    // Old contents win when a full FIFO reads and writes the same slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/fifo_flow_buf.sv
// Synchronous FIFO with watermark, pause and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output.
module fifo_flow_buf
    import fifo_flow_buf_pkg::*;
#(
    parameter int DATA_SIZE       = DEF_DATA_SIZE,
    parameter int MAIN_SIZE       = DEF_MAIN_SIZE,
    parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
    parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in_push,
    output logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);

    localparam int PW = fifo_clog2(MAIN_SIZE);
    localparam int CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_error;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_ovf;
    logic                 w_unf;
    fifo_op_e             w_op;
    logic [DATA_SIZE-1:0] w_mem_rdata;

    assign fifo_empty   = (r_count == '0);
    assign fifo_full    = (r_count == CW'(MAIN_SIZE));
    assign almost_full  = (r_count >= CW'(ALMOST_FULL_TH));
    assign almost_empty = (r_count <= CW'(ALMOST_EMPTY_TH));
    assign fifo_pause   = almost_full | fifo_full;
    assign fifo_error   = r_error;

    // A pop on the same edge frees the slot a full FIFO would need.
    assign w_rd_acc = read & ~fifo_empty;
    assign w_wr_acc = write & (~fifo_full | w_rd_acc);
    assign w_ovf    = write & fifo_full & ~read;
    assign w_unf    = read & fifo_empty;
    assign w_op     = fifo_op_e'({w_rd_acc, w_wr_acc});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            unique case (w_op)
                OP_WR:   r_count <= r_count + CW'(1);
                OP_RD:   r_count <= r_count - CW'(1);
                OP_IDLE,
                OP_RW:   r_count <= r_count;
            endcase
            if (w_ovf | w_unf) begin
                r_error <= 1'b1;
            end
        end
    end

    fifo_mem_dp #(
        .DW    (DATA_SIZE),
        .DEPTH (MAIN_SIZE)
    ) u_mem (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in_push),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    assign data_out_pop = fifo_empty ? '0 : w_mem_rdata;
`else
    assign data_out_pop = w_mem_rdata;
`endif

endmodule

// File: tb/tb_fifo_flow_buf.sv
// Bench for fifo_flow_buf: hand-written vector table plus data scoreboard.
// Works in both default and FIFO_FWFT_EN builds.
module tb_fifo_flow_buf;

    logic       clk;
    logic       reset;
    logic       write;
    logic       read;
    logic [9:0] data_in_push;
    logic [9:0] data_out_pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_pause;
    logic       fifo_error;

    fifo_flow_buf dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .data_in_push (data_in_push),
        .data_out_pop (data_out_pop),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_pause   (fifo_pause),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       wr;
        bit       rd;
        logic [9:0] din;
        int       cnt;
        bit       err;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] q[$];
    logic [9:0] exp_dout;
    int         n_run;
    int         n_fail;

    function automatic void add(bit rst, bit wr, bit rd,
                                logic [9:0] din, int cnt, bit err);
        vec_t v;
        v.rst = rst;
        v.wr  = wr;
        v.rd  = rd;
        v.din = din;
        v.cnt = cnt;
        v.err = err;
        tbl.push_back(v);
    endfunction

    task automatic chk(input int idx, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        bit         rd_acc;
        bit         wr_acc;
        logic [9:0] exp_d;
        @(negedge clk);
        reset        = v.rst;
        write        = v.wr;
        read         = v.rd;
        data_in_push = v.din;
        @(posedge clk);
        if (v.rst) begin
            q.delete();
            exp_dout = '0;
        end else begin
            rd_acc = v.rd && (q.size() > 0);
            wr_acc = v.wr && ((q.size() < 8) || rd_acc);
            if (rd_acc) exp_dout = q.pop_front();
            if (wr_acc) q.push_back(v.din);
        end
        #1;
        chk(idx, "empty",  fifo_empty,   v.cnt == 0);
        chk(idx, "full",   fifo_full,    v.cnt == 8);
        chk(idx, "afull",  almost_full,  v.cnt >= 6);
        chk(idx, "aempty", almost_empty, v.cnt <= 2);
        chk(idx, "pause",  fifo_pause,   v.cnt >= 6);
        chk(idx, "error",  fifo_error,   v.err);
`ifdef FIFO_FWFT_EN
        exp_d = (q.size() > 0) ? q[0] : 10'h000;
`else
        exp_d = exp_dout;
`endif
        chk(idx, "data", data_out_pop, exp_d);
    endtask

    initial begin
        logic [9:0] a_data [8];
        vec_t       v;
        int         idx;
        a_data = '{10'h0FF, 10'h0DD, 10'h0BB, 10'h099,
                   10'h077, 10'h055, 10'h033, 10'h011};
        n_run        = 0;
        n_fail       = 0;
        exp_dout     = '0;
        reset        = 1'b1;
        write        = 1'b0;
        read         = 1'b0;
        data_in_push = '0;

        // reset 2 cycles, release
        add(1, 0, 0, 10'h000, 0, 0);
        add(1, 0, 0, 10'h000, 0, 0);
        add(0, 0, 0, 10'h000, 0, 0);
        // fill, overflow, drain
        for (int i = 0; i < 8; i++) add(0, 1, 0, a_data[i], i + 1, 0);
        add(0, 1, 0, 10'h0BB, 8, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 10'h000, 7 - i, 1);
        // clean restart, simultaneous read+write while full
        add(1, 0, 0, 10'h000, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, 0, 10'(10'h101 + i), i + 1, 0);
        add(0, 1, 1, 10'h0AA, 8, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 10'h000, 7 - i, 0);
        // read+write while empty: write only, error set
        add(0, 1, 1, 10'h0CC, 1, 1);
        add(0, 0, 1, 10'h000, 0, 1);

        idx = 0;
        foreach (tbl[i]) begin
            apply(tbl[i], idx);
            idx++;
        end

        // pointers already wrapped; reset in the middle of a burst
        for (int i = 0; i < 5; i++) begin
            v = '{rst: 0, wr: 1, rd: 0, din: 10'(10'h1A1 + i),
                  cnt: i + 1, err: 1};
            apply(v, idx);
            idx++;
        end
        v = '{rst: 1, wr: 1, rd: 1, din: 10'h3FF, cnt: 0, err: 0};
        apply(v, idx);
        idx++;
        chk(idx, "rst_dout", data_out_pop, 32'h0);
        v = '{rst: 0, wr: 0, rd: 1, din: 10'h000, cnt: 0, err: 1};
        apply(v, idx);
        idx++;
        chk(idx, "unf_dout", data_out_pop, 32'h0);
        v = '{rst: 0, wr: 1, rd: 0, din: 10'h1EE, cnt: 1, err: 1};
        apply(v, idx);
        idx++;
        v = '{rst: 0, wr: 0, rd: 1, din: 10'h000, cnt: 0, err: 1};
        apply(v, idx);
        idx++;
`ifndef FIFO_FWFT_EN
        chk(idx, "fresh_word", data_out_pop, 32'h1EE);
`endif

        @(negedge clk);
        write = 1'b0;
        read  = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
